bch_15_7_decoder: RTL and testbench

Serial hard-decision decoder for the BCH(15,7,2) code, sitting directly downstream of the BCH(15,7) encoder in the tt_um_bch_code_15_7_2 datapath. It accepts one 15-bit received word over a valid/ready handshake and computes syndromes S1 and S3 over GF(16) bit-serially. It then solves the t=2 error-locator polynomial, runs a Chien search to correct up to two bit errors, and presents the corrected word, the message and a status.

---
 rtl/bch_15_7_decoder.sv | 180 ++++++++++++++++++
 tb/tb_bch_15_7_decoder.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/bch_15_7_decoder.sv
// Purpose: serial hard-decision BCH(15,7,2) decoder (syndromes, t=2 locator solve, Chien search).
// Latency: out_valid high 32 cycles after acceptance (17 with CHIEN_SKIP=1 and a clean word).
// Backpressure: one word in flight; in_ready only in IDLE; result held until out_ready.
// Ports: clk/rst (sync, active-high); in_valid/in_ready/in_cw[14:0] received word (bit i = x^i);
//        out_valid/out_ready, out_cw[14:0] corrected word, out_msg[6:0] = out_cw[14:8],
//        out_nerr[1:0] bits corrected, out_fail uncorrectable pattern flagged.
module bch_15_7_decoder #(
    parameter bit CHIEN_SKIP = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [14:0] in_cw,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [14:0] out_cw,
    output logic [6:0]  out_msg,
    output logic [1:0]  out_nerr,
    output logic        out_fail
);

    typedef enum logic [2:0] {IDLE, SYND, SOLVE, CHIEN, DONE} state_t;

    state_t      state, state_nxt;
    logic [14:0] work;      // word being corrected
    logic [14:0] rcv;       // untouched copy, returned on failure
    logic [3:0]  s1, s3;
    logic [3:0]  t1, t2;    // sigma1*alpha^-i and sigma2*alpha^-2i
    logic [3:0]  cnt;
    logic [2:0]  roots;
    logic [1:0]  deg;
    logic        sol_fail;

    // GF(16) multiply-by-alpha, x^4 = x + 1
    function automatic logic [3:0] mul_a(input logic [3:0] x);
        return {x[2:0], 1'b0} ^ {2'b00, x[3], x[3]};
    endfunction

    function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] p;
        logic [3:0] x;
        p = 4'h0;
        x = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) p = p ^ x;
            x = mul_a(x);
        end
        return p;
    endfunction

    // inv(alpha^k) = alpha^(15-k); entry 0 is unreachable
    function automatic logic [3:0] gf_inv(input logic [3:0] a);
        case (a)
            4'h1: return 4'h1;  4'h2: return 4'h9;  4'h3: return 4'hE;  4'h4: return 4'hD;
            4'h5: return 4'hB;  4'h6: return 4'h7;  4'h7: return 4'h6;  4'h8: return 4'hF;
            4'h9: return 4'h2;  4'hA: return 4'hC;  4'hB: return 4'h5;  4'hC: return 4'hA;
            4'hD: return 4'h4;  4'hE: return 4'h3;  4'hF: return 4'h8;
            default: return 4'h0;
        endcase
    endfunction

    logic        rbit;
    logic [3:0]  sig2;
    logic        chien_hit;
    logic [14:0] work_nxt;
    logic [2:0]  roots_nxt;
    logic        syn_zero;

    always_comb begin
        rbit      = work[4'd14 - cnt];               // MSB first for Horner evaluation
        sig2      = gf_mul(s3, gf_inv(s1)) ^ gf_mul(s1, s1);
        chien_hit = ((4'h1 ^ t1 ^ t2) == 4'h0);
        work_nxt  = chien_hit ? (work ^ (15'h1 << cnt)) : work;
        roots_nxt = roots + {2'b00, chien_hit};
        syn_zero  = (s1 == 4'h0) && (s3 == 4'h0);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = (state == IDLE);
        case (state)
            IDLE:    if (in_valid) state_nxt = SYND;
            SYND:    if (cnt == 4'd14) state_nxt = SOLVE;
            SOLVE:   state_nxt = (CHIEN_SKIP && syn_zero) ? DONE : CHIEN;
            CHIEN:   if (cnt == 4'd14) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            work      <= '0;
            rcv       <= '0;
            s1        <= '0;
            s3        <= '0;
            t1        <= '0;
            t2        <= '0;
            cnt       <= '0;
            roots     <= '0;
            deg       <= '0;
            sol_fail  <= 1'b0;
            out_valid <= 1'b0;
            out_cw    <= '0;
            out_msg   <= '0;
            out_nerr  <= '0;
            out_fail  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    work     <= in_cw;
                    rcv      <= in_cw;
                    s1       <= '0;
                    s3       <= '0;
                    cnt      <= '0;
                    roots    <= '0;
                    deg      <= '0;
                    sol_fail <= 1'b0;
                end
                SYND: begin
                    s1  <= mul_a(s1) ^ {3'b000, rbit};
                    s3  <= gf_mul(s3, 4'h8) ^ {3'b000, rbit};   // alpha^3 = 4'b1000
                    cnt <= cnt + 4'd1;
                end
                SOLVE: begin
                    cnt <= '0;
                    if (s1 == 4'h0) begin
                        // no locator; any S3 alone means more than two errors
                        t1       <= '0;
                        t2       <= '0;
                        deg      <= 2'd0;
                        sol_fail <= (s3 != 4'h0);
                    end else begin
                        t1  <= s1;
                        t2  <= sig2;
                        deg <= (sig2 == 4'h0) ? 2'd1 : 2'd2;
                    end
                    if (CHIEN_SKIP && syn_zero) begin
                        out_valid <= 1'b1;
                        out_cw    <= work;
                        out_msg   <= work[14:8];
                        out_nerr  <= 2'd0;
                        out_fail  <= 1'b0;
                    end
                end
                CHIEN: begin
                    work  <= work_nxt;
                    roots <= roots_nxt;
                    t1    <= gf_mul(t1, 4'h9);                 // alpha^-1
                    t2    <= gf_mul(t2, 4'hD);                 // alpha^-2
                    cnt   <= cnt + 4'd1;
                    // results are loaded on the last position so out_valid rises on entering DONE
                    if (cnt == 4'd14) begin
                        out_valid <= 1'b1;
                        if (sol_fail || (roots_nxt != {1'b0, deg})) begin
                            out_cw   <= rcv;
                            out_msg  <= rcv[14:8];
                            out_nerr <= 2'd0;
                            out_fail <= 1'b1;
                        end else begin
                            out_cw   <= work_nxt;
                            out_msg  <= work_nxt[14:8];
                            out_nerr <= roots_nxt[1:0];
                            out_fail <= 1'b0;
                        end
                    end
                end
                DONE: if (out_ready) out_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bch_15_7_decoder.sv
// Purpose: directed self-checking bench for bch_15_7_decoder.
// Latency: checks out_valid sampled high at the 32nd edge after acceptance.
// Backpressure: exercises held results, ignored inputs mid-decode and 33-cycle issue interval.
module tb_bch_15_7_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [14:0] in_cw;
    logic        out_valid;
    logic        out_ready;
    logic [14:0] out_cw;
    logic [6:0]  out_msg;
    logic [1:0]  out_nerr;
    logic        out_fail;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int acc_cyc = 0;

    bch_15_7_decoder #(.CHIEN_SKIP(1'b0)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_cw     (in_cw),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_cw    (out_cw),
        .out_msg   (out_msg),
        .out_nerr  (out_nerr),
        .out_fail  (out_fail)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs_zero(input string tag);
        check({tag, "_in_ready"},  32'(in_ready),  32'd1);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_cw"},    32'(out_cw),    32'd0);
        check({tag, "_out_msg"},   32'(out_msg),   32'd0);
        check({tag, "_out_nerr"},  32'(out_nerr),  32'd0);
        check({tag, "_out_fail"},  32'(out_fail),  32'd0);
    endtask

    // Observation happens #1 after an edge, so a value seen at cyc==n is what edge n+1 samples.
    task automatic decode(input string tag, input logic [14:0] cw, input logic [14:0] exp_cw,
                          input logic [1:0] exp_nerr, input logic exp_fail,
                          input int hold, input bit noise, input bit early);
        int guard;
        int lat;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1; guard++;
        end
        check({tag, "_rdy"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_cw    = cw;
        if (early) out_ready = 1'b1;
        @(posedge clk); #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
        check({tag, "_busy"}, 32'(in_ready), 32'd0);
        guard = 0;
        while (!out_valid && guard < 100) begin
            if (noise) begin
                in_valid = 1'($urandom_range(0, 1));
                in_cw    = 15'($urandom);
            end
            @(posedge clk); #1; guard++;
        end
        in_valid = 1'b0;
        lat = cyc - acc_cyc + 1;
        check({tag, "_latency"},  32'(lat),       32'd32);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_out_cw"},   32'(out_cw),    32'(exp_cw));
        check({tag, "_out_msg"},  32'(out_msg),   32'(exp_cw[14:8]));
        check({tag, "_out_nerr"}, 32'(out_nerr),  32'(exp_nerr));
        check({tag, "_out_fail"}, 32'(out_fail),  32'(exp_fail));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_hold_cw"},    32'(out_cw),    32'(exp_cw));
            check({tag, "_hold_nerr"},  32'(out_nerr),  32'(exp_nerr));
            check({tag, "_hold_rdy"},   32'(in_ready),  32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_post_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_post_rdy"},   32'(in_ready),  32'd1);
    endtask

    initial begin
        int a1;
        logic [14:0] base;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_cw     = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outs_zero("reset");
        rst = 1'b0;

        // clean codewords (15'h01D1 is g(x) itself; all-ones is a codeword since g(1)=1)
        decode("clean_01d1", 15'h01D1, 15'h01D1, 2'd0, 1'b0, 0, 1'b0, 1'b0);
        decode("clean_7fff", 15'h7FFF, 15'h7FFF, 2'd0, 1'b0, 0, 1'b0, 1'b0);
        decode("clean_0000", 15'h0000, 15'h0000, 2'd0, 1'b0, 0, 1'b0, 1'b0);

        // single and double errors
        decode("single_41d1", 15'h41D1, 15'h01D1, 2'd1, 1'b0, 0, 1'b0, 1'b0);
        decode("double_05d9", 15'h05D9, 15'h01D1, 2'd2, 1'b0, 0, 1'b0, 1'b0);

        // three errors at bits 0,1,4: S1=1+a+a^4=0, S3!=0
        decode("fail_01c2", 15'h01C2, 15'h01C2, 2'd0, 1'b1, 0, 1'b0, 1'b0);

        // backpressure held for 10 cycles, then noisy inputs during a decode
        decode("hold", 15'h05D9, 15'h01D1, 2'd2, 1'b0, 10, 1'b0, 1'b0);
        decode("noise", 15'h41D1, 15'h01D1, 2'd1, 1'b0, 0, 1'b1, 1'b0);

        // back-to-back with out_ready already high: acceptances 33 cycles apart
        decode("b2b_a", 15'h7FFF, 15'h7FFF, 2'd0, 1'b0, 0, 1'b0, 1'b1);
        a1 = acc_cyc;
        decode("b2b_b", 15'h7FFB, 15'h7FFF, 2'd1, 1'b0, 0, 1'b0, 1'b1);
        check("b2b_gap", 32'(acc_cyc - a1), 32'd33);

        // reset in the middle of the Chien search
        in_valid = 1'b1;
        in_cw    = 15'h05D9;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_outs_zero("midreset");
        decode("after_reset", 15'h41D1, 15'h01D1, 2'd1, 1'b0, 0, 1'b0, 1'b0);

        // every single-bit error on the all-ones codeword
        for (int i = 0; i < 15; i++) begin
            decode($sformatf("sweep1_b%0d", i), 15'h7FFF ^ (15'h1 << i),
                   15'h7FFF, 2'd1, 1'b0, 0, 1'b0, 1'b0);
        end

        // all 105 double-bit errors on 15'h7E2E = 15'h7FFF ^ 15'h01D1 (sum of codewords)
        base = 15'h7E2E;
        for (int i = 0; i < 14; i++) begin
            for (int j = i + 1; j < 15; j++) begin
                decode($sformatf("sweep2_b%0d_b%0d", i, j),
                       base ^ (15'h1 << i) ^ (15'h1 << j), base, 2'd2, 1'b0, 0, 1'b0, 1'b0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
